// File: rtl/serial_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx_pkg
// Description : Shared constants for the serial frame transmitter: FSM state
//               encoding, data width and serial line levels.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_frame_tx_pkg;

  // Number of payload bits in one frame
  localparam int DATA_BITS = 8;

  // Serial line levels: the line rests at the stop level between frames
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Transmitter states
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/serial_frame_tx_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Baud counter for the serial frame transmitter. Counts
//               0..CLKS_PER_BIT-1 while enabled and flags the last cycle of
//               every serial bit with a tick.
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,       // a frame is in progress
  input  logic restart,  // a new state is entered next cycle
  output logic tick      // current cycle is the last one of a serial bit
);

  localparam logic [7:0] LAST_COUNT = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick = en && (cnt_q == LAST_COUNT);

  // Next count: hold at zero when idle, wrap on bit end or state entry
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!en || restart || tick) begin
      cnt_d = '0;
    end
  end

  // Baud counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx
// Description : Byte-wide serial frame transmitter. Sends start bit, 8 data
//               bits LSB first, optional even parity bit and one stop bit,
//               each held for CLKS_PER_BIT clocks, on a registered line.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       so,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t     state_q,   state_d;
  logic [7:0] shift_q,   shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       parity_q,  parity_d;
  logic       so_q,      so_d;
  logic       tick;
  logic       restart;

  assign tx_ready   = (state_q == ST_IDLE);
  assign busy       = ~tx_ready;
  assign frame_done = (state_q == ST_STOP) && tick;
  assign so         = so_q;
  assign restart    = (state_d != state_q);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .restart (restart),
    .tick    (tick)
  );

  // Frame sequencing: capture on handshake, advance one bit per baud tick
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d   = ST_START;
          shift_d   = tx_data;
          parity_d  = ^tx_data;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level follows the state being entered so the output flop lines up
  // with the state register
  always_comb begin
    case (state_d)
      ST_START:  so_d = LINE_START;
      ST_DATA:   so_d = shift_d[0];
      ST_PARITY: so_d = parity_d;
      default:   so_d = LINE_IDLE;
    endcase
  end

  // State, datapath and line registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      so_q      <= LINE_IDLE;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      so_q      <= so_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..255.
REQ-002 Parameter PARITY_EN, default 1: 1 inserts an even-parity bit after the data bits; 0 omits it.
REQ-003 Port clk, input, 1: single clock; all logic on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port tx_data, input, 8: byte offered for transmission.
REQ-006 Port tx_valid, input, 1: tx_data is valid.
REQ-007 Port tx_ready, output, 1: block can accept a byte this cycle.
REQ-008 Port so, output, 1: serial line; idles high.
REQ-009 Port busy, output, 1: a frame is in progress.
REQ-010 Port frame_done, output, 1: one-cycle pulse at the end of a frame.

Function
REQ-011 The block SHALL have five states: IDLE, START, DATA, PARITY, STOP.
REQ-012 tx_ready SHALL be 1 only in IDLE; busy SHALL equal NOT tx_ready.
REQ-013 Handshake: a byte is accepted on the rising edge where tx_valid=1 and tx_ready=1.
REQ-014 The accepted byte SHALL be captured into an internal 8-bit shift register; tx_data changes after acceptance SHALL have no effect.
REQ-015 The state SHALL move to START on the acceptance edge; so SHALL be registered and equal 0 for the next CLKS_PER_BIT cycles.
REQ-016 DATA SHALL send 8 bits LSB first, each held for exactly CLKS_PER_BIT cycles, using a 3-bit bit counter 0..7.
REQ-017 PARITY (PARITY_EN=1) SHALL drive the XOR of the 8 accepted bits (even parity) for CLKS_PER_BIT cycles; with PARITY_EN=0, DATA SHALL go directly to STOP.
REQ-018 STOP SHALL drive so=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-019 frame_done SHALL be 1 for exactly the last cycle of STOP.
REQ-020 The baud counter SHALL count 0..CLKS_PER_BIT-1 and SHALL restart at 0 on every bit boundary and on every state entry.
REQ-021 Frame length SHALL be (10+PARITY_EN)*CLKS_PER_BIT cycles from the acceptance edge to the return to IDLE.
REQ-022 tx_ready SHALL be 1 for at least one cycle between frames; back-to-back throughput SHALL be one frame per (10+PARITY_EN)*CLKS_PER_BIT+1 cycles.
REQ-023 If tx_valid falls before a handshake, the block SHALL take no action.
REQ-024 CLKS_PER_BIT=1 SHALL work: one cycle per bit, with no skipped or duplicated bits.

Reset
REQ-025 When rst=1 at a rising edge: state=IDLE, so=1, tx_ready=1, busy=0, frame_done=0, and all counters and the shift register cleared.
REQ-026 Reset asserted mid-frame SHALL abort the frame: so=1 from the next cycle, no frame_done pulse, and no partial frame resumed after reset.

Structure
REQ-027 A shared package SHALL hold the state enumeration, DATA_BITS=8, and the stop/idle line level constant.
REQ-028 One sub-module, baud_tick_gen, SHALL hold the baud counter and emit a bit-end tick; the FSM, shift register, parity and outputs SHALL stay in serial_frame_tx.

Verification
REQ-029 Single byte, CLKS_PER_BIT=4, PARITY_EN=1, tx_data=0x12: so sequence 0,0,1,0,0,1,0,0,0,0,1, each bit 4 cycles (start, data LSB first, parity, stop); frame_done at cycle 44; tx_ready=1 at cycle 45.
REQ-030 Parity check, tx_data=0x01: parity bit=1; tx_data=0xFF: parity bit=0.
REQ-031 tx_valid held high with 0xA5 then 0x3C: the second byte is accepted exactly 1 cycle after frame_done; two complete frames with no corruption.
REQ-032 PARITY_EN=0, tx_data=0x80: frame 40 cycles; data bit 7=1 occupies cycles 33-36; stop bit follows directly.
REQ-033 Reset at cycle 20 of a 0x55 frame: so=1, tx_ready=1, busy=0 after the reset edge; no frame_done; next byte 0x0F transmits correctly.
REQ-034 CLKS_PER_BIT=1, tx_data=0xC3: 11-cycle frame, bit-exact sequence 0,1,1,0,0,0,0,1,1,0,1.
